// File: rtl/udp_tx_pkg.sv
// Shared constants, state encoding and helpers for the UDP TX framer.
// Define UDP_TX_VLAN_EN to build the 802.1Q-tagged variant (46-byte header, 64-byte minimum).
package udp_tx_pkg;

`ifdef UDP_TX_VLAN_EN
    localparam int ETH_HDR_LEN = 18;
    localparam int MIN_FRAME   = 64;
`else
    localparam int ETH_HDR_LEN = 14;
    localparam int MIN_FRAME   = 60;
`endif
    localparam int IP_HDR_LEN    = 20;
    localparam int UDP_HDR_LEN   = 8;
    localparam int HDR_LEN       = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
    localparam int MIN_PAYLOAD   = MIN_FRAME - HDR_LEN;
    localparam int IP_CSUM_WORDS = IP_HDR_LEN / 2;

    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETYPE_VLAN   = 16'h8100;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HDR,
        S_PAY,
        S_PAD,
        S_DRAIN
    } tx_state_t;

    typedef logic [5:0] hdr_idx_t;

    // One's-complement add with the end-around carry folded back in.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// Sequential IPv4 header checksum: one 16-bit header word per cycle over 10 cycles.
module ip_hdr_csum
    import udp_tx_pkg::*;
#(
    parameter logic [31:0] SRC_IP = 32'hC0A80001,
    parameter logic [31:0] DST_IP = 32'hC0A80002,
    parameter logic [7:0]  TTL    = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] total_len,
    input  logic [15:0] ip_id,
    output logic [15:0] csum,
    output logic        done
);

    logic        running;
    logic [3:0]  word_idx;
    logic [15:0] acc;
    logic [15:0] word;
    logic [15:0] acc_next;

    // Checksum field itself (word 5) is summed as zero.
    always_comb begin
        word = 16'h0000;
        case (word_idx)
            4'd0:    word = 16'h4500;
            4'd1:    word = total_len;
            4'd2:    word = ip_id;
            4'd3:    word = 16'h4000;
            4'd4:    word = {TTL, IP_PROTO_UDP};
            4'd6:    word = SRC_IP[31:16];
            4'd7:    word = SRC_IP[15:0];
            4'd8:    word = DST_IP[31:16];
            4'd9:    word = DST_IP[15:0];
            default: word = 16'h0000;
        endcase
    end

    assign acc_next = ones_add(acc, word);
    assign done     = running && (word_idx == 4'(IP_CSUM_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running  <= 1'b0;
            word_idx <= 4'd0;
            acc      <= 16'h0000;
            csum     <= 16'h0000;
        end else if (start) begin
            running  <= 1'b1;
            word_idx <= 4'd0;
            acc      <= 16'h0000;
        end else if (running) begin
            acc      <= acc_next;
            word_idx <= word_idx + 4'd1;
            if (done) begin
                running <= 1'b0;
                csum    <= ~acc_next;
            end
        end
    end

endmodule

// File: rtl/udp_tx_framer.sv
// Wraps a length-tagged payload stream into an Ethernet II / IPv4 / UDP frame (no FCS).
// Define UDP_TX_VLAN_EN to insert an 802.1Q tag (adds VLAN_TCI parameter).
module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] SRC_IP      = 32'hC0A80001,
    parameter logic [31:0] DST_IP      = 32'hC0A80002,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5001,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          MAX_PAYLOAD = 1472
`ifdef UDP_TX_VLAN_EN
    ,
    parameter logic [15:0] VLAN_TCI    = 16'h0001
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_len,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic        err_len,
    output logic [15:0] frame_cnt
);

    tx_state_t   state;
    logic [15:0] len_q;
    logic [15:0] byte_cnt;
    hdr_idx_t    hdr_idx;
    logic [5:0]  pad_cnt;
    logic        bad_q;
    logic        fill_q;
    logic [15:0] ip_id;
    logic [15:0] ip_csum;
    logic        csum_done;

    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic        len_bad;
    logic        csum_start;
    logic        short_frame;
    logic        last_pay;
    logic        late_end;
    logic        pay_beat;
    logic        pay_tlast;
    logic [5:0]  pad_len;
    logic [7:0]  hdr_byte;
    logic [HDR_LEN*8-1:0] hdr_vec;

    assign total_len   = len_q + 16'(IP_HDR_LEN + UDP_HDR_LEN);
    assign udp_len     = len_q + 16'(UDP_HDR_LEN);
    assign len_bad     = (req_len == 16'd0) || (req_len > 16'(MAX_PAYLOAD));
    assign csum_start  = (state == S_IDLE) && req_valid && !len_bad;
    assign short_frame = len_q < 16'(MIN_PAYLOAD);
    assign last_pay    = byte_cnt == 16'd1;
    assign late_end    = !fill_q && !s_axis_tlast;
    assign pay_beat    = m_axis_tready && (fill_q || s_axis_tvalid);
    assign pay_tlast   = last_pay && !short_frame;
    assign pad_len     = 6'(MIN_PAYLOAD) - len_q[5:0];

    assign hdr_vec = {DST_MAC, SRC_MAC,
`ifdef UDP_TX_VLAN_EN
                      ETYPE_VLAN, VLAN_TCI,
`endif
                      ETYPE_IPV4, 8'h45, 8'h00, total_len, ip_id, 16'h4000,
                      TTL, IP_PROTO_UDP, ip_csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udp_len, 16'h0000};
    assign hdr_byte = hdr_vec[(HDR_LEN - 1 - int'(hdr_idx))*8 +: 8];

    ip_hdr_csum #(
        .SRC_IP (SRC_IP),
        .DST_IP (DST_IP),
        .TTL    (TTL)
    ) u_csum (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (csum_start),
        .total_len (total_len),
        .ip_id     (ip_id),
        .csum      (ip_csum),
        .done      (csum_done)
    );

    // Frame sequencing; a short frame that overruns its length drains first, then pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= 16'd0;
            byte_cnt  <= 16'd0;
            hdr_idx   <= '0;
            pad_cnt   <= 6'd0;
            bad_q     <= 1'b0;
            fill_q    <= 1'b0;
            ip_id     <= 16'd0;
            frame_cnt <= 16'd0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (len_bad) begin
                            err_len <= 1'b1;
                        end else begin
                            len_q    <= req_len;
                            byte_cnt <= req_len;
                            hdr_idx  <= '0;
                            bad_q    <= 1'b0;
                            fill_q   <= 1'b0;
                            state    <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (csum_done) state <= S_HDR;
                end
                S_HDR: begin
                    if (m_axis_tready) begin
                        if (hdr_idx == hdr_idx_t'(HDR_LEN - 1)) state <= S_PAY;
                        else hdr_idx <= hdr_idx + 1'b1;
                    end
                end
                S_PAY: begin
                    if (pay_beat) begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (last_pay) begin
                            if (!short_frame) begin
                                frame_cnt <= frame_cnt + 16'd1;
                                ip_id     <= ip_id + 16'd1;
                                state     <= late_end ? S_DRAIN : S_IDLE;
                            end else begin
                                bad_q   <= bad_q | late_end;
                                pad_cnt <= pad_len;
                                state   <= late_end ? S_DRAIN : S_PAD;
                            end
                        end else if (!fill_q && s_axis_tlast) begin
                            fill_q <= 1'b1;
                            bad_q  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) state <= short_frame ? S_PAD : S_IDLE;
                end
                S_PAD: begin
                    if (m_axis_tready) begin
                        if (pad_cnt == 6'd1) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            ip_id     <= ip_id + 16'd1;
                            state     <= S_IDLE;
                        end else begin
                            pad_cnt <= pad_cnt - 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode; payload passes straight through so it adds no latency.
    always_comb begin
        req_ready     = (state == S_IDLE);
        busy          = (state != S_IDLE);
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
            end
            S_PAY: begin
                m_axis_tlast = pay_tlast;
                if (fill_q) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tuser  = pay_tlast;
                end else begin
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tdata  = s_axis_tdata;
                    s_axis_tready = m_axis_tready;
                    m_axis_tuser  = pay_tlast && !s_axis_tlast;
                end
            end
            S_DRAIN: s_axis_tready = 1'b1;
            S_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (pad_cnt == 6'd1);
                m_axis_tuser  = (pad_cnt == 6'd1) && bad_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed, table-driven bench for udp_tx_framer (default build, no VLAN tag).
module tb_udp_tx_framer;

    localparam logic [47:0] T_SRC_MAC  = 48'h000A35000001;
    localparam logic [47:0] T_DST_MAC  = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] T_SRC_IP   = 32'hC0A80001;
    localparam logic [31:0] T_DST_IP   = 32'hC0A80002;
    localparam logic [15:0] T_SRC_PORT = 16'd5000;
    localparam logic [15:0] T_DST_PORT = 16'd5001;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_len;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        err_len;
    logic [15:0] frame_cnt;

    udp_tx_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_len       (req_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .err_len       (err_len),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int src_total;
        int ready_pct;
        bit is_err;
        int exp_bytes;
        bit exp_tuser;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int   src_idx, src_total;
    int   unstable, err_pulses, lat;
    bit   hold_pending, got_last, got_user, any_valid;
    logic [7:0] held_data;
    int   exp_frames, exp_id;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] patByte(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    function automatic logic [15:0] refCsum(input int len, input int id);
        logic [31:0] s;
        s = 32'h4500 + 32'(len + 28) + 32'(id & 16'hFFFF) + 32'h4000 + 32'h4011
            + 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h0002;
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endtask

    task automatic buildExpected(input int len, input int srcn, input int id);
        exp_q.delete();
        for (int i = 5; i >= 0; i--) exp_q.push_back(T_DST_MAC[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(T_SRC_MAC[i*8 +: 8]);
        push16(16'h0800);
        push16(16'h4500);
        push16(16'(len + 28));
        push16(16'(id));
        push16(16'h4000);
        push16(16'h4011);
        push16(refCsum(len, id));
        push16(T_SRC_IP[31:16]);
        push16(T_SRC_IP[15:0]);
        push16(T_DST_IP[31:16]);
        push16(T_DST_IP[15:0]);
        push16(T_SRC_PORT);
        push16(T_DST_PORT);
        push16(16'(len + 8));
        push16(16'h0000);
        for (int i = 1; i <= len; i++) exp_q.push_back((i <= srcn) ? patByte(i) : 8'h00);
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endtask

    // One cycle: drive at the falling edge, sample 1ns later for the coming rising edge.
    task automatic stepCycle(input bit req, input int pct, input int cyc);
        @(negedge clk);
        req_valid     = req;
        m_axis_tready = (pct == 0) ? 1'b1 : ($urandom_range(99) < pct);
        s_axis_tvalid = (src_idx < src_total);
        s_axis_tdata  = patByte(src_idx + 1);
        s_axis_tlast  = (src_idx + 1 == src_total);
        #1;
        if (hold_pending && (!m_axis_tvalid || m_axis_tdata !== held_data)) unstable++;
        hold_pending = m_axis_tvalid && !m_axis_tready;
        held_data    = m_axis_tdata;
        if (m_axis_tvalid && lat < 0) lat = cyc;
        if (m_axis_tvalid) any_valid = 1'b1;
        if (m_axis_tvalid && m_axis_tready && !got_last) begin
            rx.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
                got_last = 1'b1;
                got_user = m_axis_tuser;
            end
        end
        if (s_axis_tvalid && s_axis_tready) src_idx++;
        if (err_len) err_pulses++;
    endtask

    task automatic applyStimulus(input vec_t v, input int abort_after);
        bit finished;
        rx.delete();
        src_idx = 0; src_total = v.src_total;
        unstable = 0; err_pulses = 0; lat = -1;
        hold_pending = 0; got_last = 0; got_user = 0; any_valid = 0;
        req_len = 16'(v.len);
        stepCycle(1'b1, v.ready_pct, 0);
        for (int c = 1; c < 20000; c++) begin
            stepCycle(1'b0, v.ready_pct, c);
            if (abort_after > 0 && rx.size() >= abort_after) return;
            if (v.is_err && c >= 15) break;
            if (!v.is_err && got_last && !busy) break;
        end
        if (v.is_err) begin
            checkOutput($sformatf("err_pulse len=%0d", v.len), 32'(err_pulses), 32'd1);
            checkOutput($sformatf("err_no_valid len=%0d", v.len), 32'(any_valid), 32'd0);
            checkOutput($sformatf("err_frame_cnt len=%0d", v.len), 32'(frame_cnt), 32'(exp_frames));
        end else begin
            finished = got_last && !busy;
            checkOutput($sformatf("done len=%0d", v.len), 32'(finished), 32'd1);
            buildExpected(v.len, v.src_total, exp_id);
            exp_frames++;
            exp_id++;
            checkOutput($sformatf("latency len=%0d", v.len), 32'(lat), 32'd11);
            checkOutput($sformatf("frame_len len=%0d", v.len), 32'(rx.size()), 32'(v.exp_bytes));
            checkOutput($sformatf("model_len len=%0d", v.len), 32'(rx.size()), 32'(exp_q.size()));
            begin
                int bad_bytes = 0;
                for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
                    if (rx[i] !== exp_q[i]) bad_bytes++;
                checkOutput($sformatf("byte_errors len=%0d", v.len), 32'(bad_bytes), 32'd0);
            end
            checkOutput($sformatf("tuser len=%0d", v.len), 32'(got_user), 32'(v.exp_tuser));
            checkOutput($sformatf("stable len=%0d", v.len), 32'(unstable), 32'd0);
            checkOutput($sformatf("frame_cnt len=%0d", v.len), 32'(frame_cnt), 32'(exp_frames));
            checkOutput($sformatf("err_quiet len=%0d", v.len), 32'(err_pulses), 32'd0);
        end
    endtask

    vec_t vecs[11];
    vec_t v_abort, v_after;

    initial begin
        vecs[0]  = '{100, 100, 0, 0, 142, 0};
        vecs[1]  = '{1, 1, 0, 0, 60, 0};
        vecs[2]  = '{18, 18, 0, 0, 60, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 0};
        vecs[4]  = '{1473, 0, 0, 1, 0, 0};
        vecs[5]  = '{50, 40, 0, 0, 92, 1};
        vecs[6]  = '{20, 25, 30, 0, 62, 1};
        vecs[7]  = '{5, 8, 0, 0, 60, 1};
        vecs[8]  = '{10, 3, 50, 0, 60, 1};
        vecs[9]  = '{17, 17, 50, 0, 60, 0};
        vecs[10] = '{1472, 1472, 50, 0, 1514, 0};
        v_abort  = '{100, 100, 0, 0, 142, 0};
        v_after  = '{64, 64, 50, 0, 106, 0};

        exp_frames = 0; exp_id = 0;
        src_idx = 0; src_total = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_len = 16'd0;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        #2;
        checkOutput("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], 0);
            if (vecs[i].len == 100) begin
                checkOutput("len100_total_len", {16'd0, rx[16], rx[17]}, 32'h0080);
                checkOutput("len100_udp_len", {16'd0, rx[38], rx[39]}, 32'h006C);
                checkOutput("len100_csum", {16'd0, rx[24], rx[25]}, 32'hB919);
                checkOutput("len100_tlast_byte", {24'd0, rx[141]}, {24'd0, patByte(100)});
            end
        end

        // Abandon a frame in the middle of its payload with an asynchronous reset.
        applyStimulus(v_abort, 60);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("midreset_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("midreset_tuser", 32'(m_axis_tuser), 32'd0);
        checkOutput("midreset_s_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; src_idx = 0; src_total = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0; exp_id = 0;

        applyStimulus(v_after, 0);
        checkOutput("ip_id_after_reset", {16'd0, rx[18], rx[19]}, 32'd0);
        applyStimulus(v_after, 0);
        checkOutput("ip_id_second", {16'd0, rx[18], rx[19]}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
